// File: rtl/realign_queue.sv
// Halfword realignment queue between fetch and decode.
// Splits aligned fetch words and presents whole RV32/RVC instructions with their address.
module realign_queue #(
    parameter int unsigned           DEPTH         = 4,
    parameter int unsigned           ADDR_WIDTH    = 32,
    parameter bit                    EN_COMPRESSED = 1'b1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [ADDR_WIDTH-1:0]         flush_addr_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [31:0]                   in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_instr_o,
    output logic [ADDR_WIDTH-1:0]         out_addr_o,
    output logic                          out_compressed_o,
    output logic [$clog2(2*DEPTH):0]      count_o
);

    localparam int unsigned SLOTS = 2 * DEPTH;
    localparam int unsigned PW    = $clog2(SLOTS);
    localparam int unsigned CW    = PW + 1;

    logic [15:0]           hw [SLOTS];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  skip_q;

    logic [PW-1:0]         rd_next;
    logic [PW-1:0]         wr_next;
    logic [15:0]           h0;
    logic [15:0]           h1;
    logic                  is_c;
    logic                  head_ok;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         push_n;
    logic [CW-1:0]         pop_n;
    logic                  unused_bit0;

    assign unused_bit0 = flush_addr_i[0];

    assign rd_next = rd_ptr + PW'(1);
    assign wr_next = wr_ptr + PW'(1);
    assign h0      = hw[rd_ptr];
    assign h1      = hw[rd_next];

    assign is_c    = EN_COMPRESSED && (h0[1:0] != 2'b11);
    assign head_ok = is_c ? (count >= CW'(1)) : (count >= CW'(2));

    // Ready looks only at the registered fill level so it never depends on decode.
    assign in_ready_o = (count <= CW'(SLOTS - 2));

    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = head_ok && out_ready_i && !flush_i;

    assign push_n = push ? (skip_q ? CW'(1) : CW'(2)) : CW'(0);
    assign pop_n  = pop ? (is_c ? CW'(1) : CW'(2)) : CW'(0);

    always_comb begin
        out_valid_o      = head_ok;
        out_compressed_o = is_c && head_ok;
        out_addr_o       = pc_q;
        count_o          = count;
        out_instr_o      = 32'h0;
        if (head_ok) begin
            out_instr_o = is_c ? {16'h0, h0} : {h1, h0};
        end
    end

    // Storage carries no reset; stale entries are never presented.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (skip_q) begin
                hw[wr_ptr] <= in_data_i[31:16];
            end else begin
                hw[wr_ptr]  <= in_data_i[15:0];
                hw[wr_next] <= in_data_i[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= RESET_PC;
            skip_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc_q   <= {flush_addr_i[ADDR_WIDTH-1:1], 1'b0};
            skip_q <= EN_COMPRESSED && flush_addr_i[1];
        end else begin
            count  <= count + push_n - pop_n;
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(push_n);
            if (pop) begin
                pc_q <= pc_q + (is_c ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
            end
            if (push) begin
                skip_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_realign_queue.sv
// Bench for realign_queue: directed vectors then a random run
// against a halfword queue model.
module tb_realign_queue;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_compressed_o;
    logic [3:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    realign_queue #(
        .DEPTH(4),
        .ADDR_WIDTH(32),
        .EN_COMPRESSED(1'b1),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .flush_addr_i(flush_addr_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_data_i(in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o),
        .out_addr_o(out_addr_o),
        .out_compressed_o(out_compressed_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_to(input logic [31:0] a);
        flush_i      = 1'b1;
        flush_addr_i = a;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        in_valid_i = 1'b1;
        in_data_i  = d;
        tick();
        in_valid_i = 1'b0;
    endtask

    logic [15:0] q[$];
    logic [31:0] m_pc;
    bit          m_skip;

    initial begin
        int  sz;
        bit  e_c, e_valid, e_ready;
        logic [31:0] e_instr;
        bit  r_rst, r_fl, iv, ordy;
        logic [31:0] fa, data;

        rst          = 1'b1;
        flush_i      = 1'b0;
        flush_addr_i = 32'h0;
        in_valid_i   = 1'b0;
        in_data_i    = 32'h0;
        out_ready_i  = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: reset state
        check("rst_valid", out_valid_o, 0);
        check("rst_ready", in_ready_o, 1);
        check("rst_count", count_o, 0);
        check("rst_addr", out_addr_o, 32'h0);
        check("rst_instr", out_instr_o, 0);
        check("rst_comp", out_compressed_o, 0);

        // 2: one 32-bit instruction
        flush_to(32'h100);
        push_word(32'h0000_0013);
        check("t2_valid", out_valid_o, 1);
        check("t2_instr", out_instr_o, 32'h0000_0013);
        check("t2_addr", out_addr_o, 32'h100);
        check("t2_comp", out_compressed_o, 0);
        check("t2_count", count_o, 2);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("t2_addr2", out_addr_o, 32'h104);
        check("t2_count2", count_o, 0);
        check("t2_valid2", out_valid_o, 0);

        // 3: two compressed in one word
        flush_to(32'h100);
        push_word(32'h4501_4501);
        check("t3_instr0", out_instr_o, 32'h0000_4501);
        check("t3_addr0", out_addr_o, 32'h100);
        check("t3_comp0", out_compressed_o, 1);
        out_ready_i = 1'b1;
        tick();
        check("t3_instr1", out_instr_o, 32'h0000_4501);
        check("t3_addr1", out_addr_o, 32'h102);
        check("t3_comp1", out_compressed_o, 1);
        check("t3_count1", count_o, 1);
        tick();
        out_ready_i = 1'b0;
        check("t3_count2", count_o, 0);
        check("t3_addr2", out_addr_o, 32'h104);

        // 4: 32-bit instruction straddling two words
        flush_to(32'h100);
        in_valid_i  = 1'b1;
        in_data_i   = 32'h0013_4501;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("t4_valid0", out_valid_o, 1);
        check("t4_instr0", out_instr_o, 32'h0000_4501);
        check("t4_addr0", out_addr_o, 32'h100);
        tick();
        out_ready_i = 1'b0;
        check("t4_hold_valid", out_valid_o, 0);
        check("t4_hold_count", count_o, 1);
        check("t4_hold_addr", out_addr_o, 32'h102);
        check("t4_hold_instr", out_instr_o, 0);
        push_word(32'h0000_0000);
        check("t4_valid1", out_valid_o, 1);
        check("t4_instr1", out_instr_o, 32'h0000_0013);
        check("t4_addr1", out_addr_o, 32'h102);
        check("t4_comp1", out_compressed_o, 0);
        check("t4_count1", count_o, 3);

        // 5: misaligned redirect drops the low half
        flush_to(32'h202);
        push_word(32'h4501_ABCD);
        check("t5_count", count_o, 1);
        check("t5_instr", out_instr_o, 32'h0000_4501);
        check("t5_addr", out_addr_o, 32'h202);
        check("t5_comp", out_compressed_o, 1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("t5_count2", count_o, 0);
        check("t5_valid2", out_valid_o, 0);
        check("t5_addr2", out_addr_o, 32'h204);

        // 6: fill, then flush with a push pending
        flush_to(32'h0);
        for (int k = 0; k < 4; k++) push_word(32'h0000_0013);
        check("t6_full_count", count_o, 8);
        check("t6_full_ready", in_ready_o, 0);
        in_valid_i   = 1'b1;
        in_data_i    = 32'h1234_5678;
        flush_i      = 1'b1;
        flush_addr_i = 32'h300;
        tick();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("t6_fl_count", count_o, 0);
        check("t6_fl_valid", out_valid_o, 0);
        check("t6_fl_ready", in_ready_o, 1);
        check("t6_fl_addr", out_addr_o, 32'h300);

        // odd fill level leaves no room for a whole word
        flush_to(32'h302);
        for (int k = 0; k < 4; k++) push_word(32'h0000_0013);
        check("odd_count", count_o, 7);
        check("odd_ready", in_ready_o, 0);
        push_word(32'h0000_0013);
        check("odd_count2", count_o, 7);

        // reset beats flush
        rst          = 1'b1;
        flush_i      = 1'b1;
        flush_addr_i = 32'h400;
        tick();
        rst     = 1'b0;
        flush_i = 1'b0;
        check("rstfl_addr", out_addr_o, 32'h0);
        check("rstfl_count", count_o, 0);

        // random run vs model
        q.delete();
        m_pc   = 32'h0;
        m_skip = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            sz      = q.size();
            e_c     = (sz >= 1) && (q[0][1:0] != 2'b11);
            e_valid = (sz >= 1) && (e_c || sz >= 2);
            e_ready = (sz <= 6);
            e_instr = 32'h0;
            if (e_valid) e_instr = e_c ? {16'h0, q[0]} : {q[1], q[0]};
            check("rnd_valid", out_valid_o, e_valid);
            check("rnd_instr", out_instr_o, e_instr);
            check("rnd_addr", out_addr_o, m_pc);
            check("rnd_comp", out_compressed_o, e_c && e_valid);
            check("rnd_count", count_o, sz);
            check("rnd_ready", in_ready_o, e_ready);

            r_rst = (i == 0) || (i == 700) || (i == 1100);
            r_fl  = ($urandom_range(0, 59) == 0) || (i == 1100);
            fa    = $urandom;
            iv    = ($urandom_range(0, 3) != 0);
            data  = $urandom;
            ordy  = ((i % 300) < 100) ? ($urandom_range(0, 5) == 0)
                                      : ($urandom_range(0, 2) != 0);

            rst          = r_rst;
            flush_i      = r_fl;
            flush_addr_i = fa;
            in_valid_i   = iv;
            in_data_i    = data;
            out_ready_i  = ordy;

            if (r_rst) begin
                q.delete();
                m_pc   = 32'h0;
                m_skip = 1'b0;
            end else if (r_fl) begin
                q.delete();
                m_pc   = {fa[31:1], 1'b0};
                m_skip = fa[1];
            end else begin
                if (e_valid && ordy) begin
                    void'(q.pop_front());
                    if (!e_c) void'(q.pop_front());
                    m_pc = m_pc + (e_c ? 32'd2 : 32'd4);
                end
                if (iv && e_ready) begin
                    if (m_skip) begin
                        q.push_back(data[31:16]);
                        m_skip = 1'b0;
                    end else begin
                        q.push_back(data[15:0]);
                        q.push_back(data[31:16]);
                    end
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
